// File: rtl/divisor_reloj_programable.sv
// divisor_reloj_programable: runtime-programmable clock divider with a shadow-loaded divisor, tick strobe and period counter
module divisor_reloj_programable #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 5000000,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] period_count
);
  logic [WIDTH-1:0] counter, div_q, shadow, div_clamp;
  logic term;
  always_comb begin
    div_clamp = (div_in == '0) ? WIDTH'(1) : div_in;
    term = enable && (counter == div_q - WIDTH'(1));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      div_q        <= WIDTH'(DEFAULT_DIV);
      shadow       <= '0;
      div_busy     <= 1'b0;
      clk_out      <= 1'b1;
      tick         <= 1'b0;
      period_count <= '0;
    end else if (!enable) begin
      tick <= 1'b0;
      if (mode) clk_out <= 1'b0;
      if (div_busy) begin
        div_q    <= shadow;
        counter  <= '0;
        div_busy <= 1'b0;
      end
      if (div_load) begin
        div_q   <= div_clamp;
        counter <= '0;
      end
    end else begin
      tick    <= term;
      clk_out <= mode ? term : (term ? ~clk_out : clk_out);
      counter <= term ? '0 : counter + WIDTH'(1);
      if (term) period_count <= period_count + CNT_W'(1);
      // a pending divisor only takes over at a period boundary
      if (term && div_busy) begin
        div_q    <= shadow;
        div_busy <= 1'b0;
      end
      if (div_load) begin
        shadow   <= div_clamp;
        div_busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_divisor_reloj_programable.sv
// tb_divisor_reloj_programable: randomized bench against a period-level reference model
module tb_divisor_reloj_programable;
  logic clock = 0, reset = 1, enable = 0, mode = 0, div_load = 0;
  logic [7:0] div_in = 0;
  logic div_busy, clk_out, tick;
  logic [7:0] period_count;
  int tests = 0, fails = 0;
  int m_el, m_n, m_sh, m_pc;
  bit m_busy, m_clk, m_tick;

  divisor_reloj_programable #(.WIDTH(8), .DEFAULT_DIV(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .div_in(div_in),
    .div_load(div_load), .div_busy(div_busy), .clk_out(clk_out), .tick(tick),
    .period_count(period_count)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] exp_vec();
    return {m_clk, m_tick, m_busy, 8'(m_pc)};
  endfunction

  task automatic model_reset();
    m_el = 0; m_n = 4; m_sh = 0; m_pc = 0; m_busy = 0; m_clk = 1; m_tick = 0;
  endtask

  task automatic step(input bit en, input bit md, input bit ld, input int din);
    int cl;
    bit t;
    enable = en; mode = md; div_load = ld; div_in = 8'(din);
    cl = (din == 0) ? 1 : din;
    if (!en) begin
      m_tick = 0;
      if (md) m_clk = 0;
      if (m_busy) begin m_n = m_sh; m_el = 0; m_busy = 0; end
      if (ld) begin m_n = cl; m_el = 0; end
    end else begin
      t = (m_el == m_n - 1);
      m_tick = t;
      m_clk = md ? t : (t ? !m_clk : m_clk);
      if (t) begin
        m_el = 0;
        m_pc = (m_pc + 1) % 256;
        if (m_busy) begin m_n = m_sh; m_busy = 0; end
      end else m_el++;
      if (ld) begin m_sh = cl; m_busy = 1; end
    end
    @(posedge clock); #1;
    div_load = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({clk_out, tick, div_busy, period_count} !== 11'b1_0_0_00000000) begin
      fails++; $display("FAIL reset: got %b want %b", {clk_out, tick, div_busy, period_count}, 11'b10000000000);
    end
  endtask

  task automatic test_default();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL default[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
    tests++;
    if (period_count !== 8'd3) begin
      fails++; $display("FAIL default_count: got %0d want 3", period_count);
    end
  endtask

  task automatic test_mode1();
    step(0, 1, 1, 3);
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec() || clk_out !== tick) begin
        fails++; $display("FAIL mode1_n3[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
    step(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec() || clk_out !== 1'b1) begin
        fails++; $display("FAIL mode1_n1[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  task automatic test_load_busy();
    int gap, last;
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 2);
    last = 2; gap = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL load_busy[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
      if (tick === 1'b1 && gap == 0) gap = i + 3;
    end
    tests++;
    if (gap != 4) begin
      fails++; $display("FAIL load_busy_first_period: got %0d want 4", gap);
    end
    step(1, 0, 1, 6);
    step(1, 0, 1, 3);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL last_write_wins[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
    step(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL load_zero[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  task automatic test_enable();
    step(0, 0, 1, 5);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL freeze[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
    step(0, 0, 1, 3);
    step(1, 0, 1, 5);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL reenable[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 1, 7);
    step(1, 0, 0, 0);
    #2 reset = 1;
    #1;
    tests++;
    if ({clk_out, tick, div_busy, period_count} !== 11'b1_0_0_00000000) begin
      fails++; $display("FAIL async_reset: got %b want %b", {clk_out, tick, div_busy, period_count}, 11'b10000000000);
    end
    @(posedge clock); #1 reset = 0;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL after_reset[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 1);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 0);
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec() || tick !== 1'b1) begin
        fails++; $display("FAIL wrap[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9) != 0, $urandom_range(19) == 0 ? !mode : mode,
           $urandom_range(11) == 0, $urandom_range(6));
      tests++;
      if ({clk_out, tick, div_busy, period_count} !== exp_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h want %h", i, {clk_out, tick, div_busy, period_count}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_mode1();
    test_load_busy();
    test_enable();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
